// File: rtl/reg_file_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// Holds the default width/depth and the zero-register and bypass options.
package reg_file_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam bit DEF_ZERO_REG0 = 1'b0;
    localparam bit DEF_BYPASS    = 1'b0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit array: one bit per register, marking a pending producer.
// Ports: CLK, RESET (sync, active-high), i_set/i_set_addr sets a bit,
// i_clr1/i_clr2 with addresses clear bits, i_q1/i_q2 addresses query bits.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr1,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic              i_clr2,
    input  logic [ADDR_W-1:0] i_clr2_addr,
    input  logic [ADDR_W-1:0] i_q1_addr,
    input  logic [ADDR_W-1:0] i_q2_addr,
    output logic              o_q1_busy,
    output logic              o_q2_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;

    // A reserve in the same cycle as a write to that register wins,
    // since the newly reserved producer has not delivered yet.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_set && (i_set_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((i_clr1 && (i_clr1_addr == ADDR_W'(i))) ||
                             (i_clr2 && (i_clr2_addr == ADDR_W'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign o_q1_busy = r_busy[i_q1_addr];
    assign o_q2_busy = r_busy[i_q2_addr];

endmodule

// File: rtl/reg_file_multi.sv
// Two-write, two-read register file with busy scoreboard, optional
// zero register, optional write-to-read bypass and a collision flag.
// Ports: CLK, RESET (sync), WRITE1/2 + INADDRESS1/2 + IN1/2 write ports,
// OUT1/2ADDRESS -> OUT1/2 + OUT1/2VALID reads, RESERVE/RESADDRESS, COLLISION.
module reg_file_multi
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit ZERO_REG0 = DEF_ZERO_REG0,
    parameter bit BYPASS    = DEF_BYPASS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITE1,
    input  logic              WRITE2,
    input  logic [ADDR_W-1:0] INADDRESS1,
    input  logic [ADDR_W-1:0] INADDRESS2,
    input  logic [DATA_W-1:0] IN1,
    input  logic [DATA_W-1:0] IN2,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT1VALID,
    output logic              OUT2VALID,
    input  logic              RESERVE,
    input  logic [ADDR_W-1:0] RESADDRESS,
    output logic              COLLISION
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_collision;

    logic              w_wr1;
    logic              w_wr2_req;
    logic              w_wr2;
    logic              w_res;
    logic              w_coll;
    logic [ADDR_W-1:0] w_raddr  [2];
    logic              w_busy   [2];
    logic [DATA_W-1:0] w_rdata  [2];
    logic              w_rvalid [2];

    // Effective strobes: nothing happens under reset, and register 0
    // swallows writes and reserves when it is hardwired to zero.
    assign w_wr1 = WRITE1 && !RESET &&
                   !(ZERO_REG0 && (INADDRESS1 == '0));
    assign w_wr2_req = WRITE2 && !RESET &&
                       !(ZERO_REG0 && (INADDRESS2 == '0));
    assign w_res = RESERVE && !RESET &&
                   !(ZERO_REG0 && (RESADDRESS == '0));

    // Port 1 owns a shared target; port 2 is dropped and flagged.
    assign w_coll = w_wr1 && w_wr2_req && (INADDRESS1 == INADDRESS2);
    assign w_wr2  = w_wr2_req && !w_coll;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_collision <= 1'b0;
        end else begin
            if (w_wr2) begin
                r_mem[INADDRESS2] <= IN2;
            end
            if (w_wr1) begin
                r_mem[INADDRESS1] <= IN1;
            end
            r_collision <= w_coll;
        end
    end

    assign COLLISION = r_collision;

    reg_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_set      (w_res),
        .i_set_addr (RESADDRESS),
        .i_clr1     (w_wr1),
        .i_clr1_addr(INADDRESS1),
        .i_clr2     (w_wr2),
        .i_clr2_addr(INADDRESS2),
        .i_q1_addr  (OUT1ADDRESS),
        .i_q2_addr  (OUT2ADDRESS),
        .o_q1_busy  (w_busy[0]),
        .o_q2_busy  (w_busy[1])
    );

    assign w_raddr[0] = OUT1ADDRESS;
    assign w_raddr[1] = OUT2ADDRESS;

    // Port 2 forwarding is applied first so port 1 overrides it.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p]  = r_mem[w_raddr[p]];
            w_rvalid[p] = !w_busy[p];
            if (BYPASS) begin
                if (w_wr2 && (INADDRESS2 == w_raddr[p])) begin
                    w_rdata[p]  = IN2;
                    w_rvalid[p] = !(w_res && (RESADDRESS == w_raddr[p]));
                end
                if (w_wr1 && (INADDRESS1 == w_raddr[p])) begin
                    w_rdata[p]  = IN1;
                    w_rvalid[p] = !(w_res && (RESADDRESS == w_raddr[p]));
                end
            end
            if (ZERO_REG0 && (w_raddr[p] == '0)) begin
                w_rdata[p]  = '0;
                w_rvalid[p] = 1'b1;
            end
        end
    end

    assign OUT1      = w_rdata[0];
    assign OUT2      = w_rdata[1];
    assign OUT1VALID = w_rvalid[0];
    assign OUT2VALID = w_rvalid[1];

endmodule

// File: tb/tb_reg_file_multi.sv
// Directed bench for reg_file_multi: instance a uses the defaults,
// instance b has BYPASS=1 and ZERO_REG0=1; both share the same stimulus.
module tb_reg_file_multi;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITE1, WRITE2, RESERVE;
    logic [2:0] INADDRESS1, INADDRESS2, OUT1ADDRESS, OUT2ADDRESS, RESADDRESS;
    logic [7:0] IN1, IN2;

    logic [7:0] a_OUT1, a_OUT2, b_OUT1, b_OUT2;
    logic       a_V1, a_V2, b_V1, b_V2, a_COLL, b_COLL;

    int nvec = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    reg_file_multi u_a (
        .CLK(CLK), .RESET(RESET),
        .WRITE1(WRITE1), .WRITE2(WRITE2),
        .INADDRESS1(INADDRESS1), .INADDRESS2(INADDRESS2),
        .IN1(IN1), .IN2(IN2),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(a_OUT1), .OUT2(a_OUT2),
        .OUT1VALID(a_V1), .OUT2VALID(a_V2),
        .RESERVE(RESERVE), .RESADDRESS(RESADDRESS),
        .COLLISION(a_COLL)
    );

    reg_file_multi #(
        .ZERO_REG0(1'b1), .BYPASS(1'b1)
    ) u_b (
        .CLK(CLK), .RESET(RESET),
        .WRITE1(WRITE1), .WRITE2(WRITE2),
        .INADDRESS1(INADDRESS1), .INADDRESS2(INADDRESS2),
        .IN1(IN1), .IN2(IN2),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(b_OUT1), .OUT2(b_OUT2),
        .OUT1VALID(b_V1), .OUT2VALID(b_V2),
        .RESERVE(RESERVE), .RESADDRESS(RESADDRESS),
        .COLLISION(b_COLL)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        RESET = 1'b0; WRITE1 = 1'b0; WRITE2 = 1'b0; RESERVE = 1'b0;
        INADDRESS1 = '0; INADDRESS2 = '0; IN1 = '0; IN2 = '0;
        RESADDRESS = '0;
    endtask

    initial begin
        idle();
        OUT1ADDRESS = '0;
        OUT2ADDRESS = '0;

        // reset then sweep every address
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a);
            OUT2ADDRESS = 3'(7 - a);
            #1;
            chk($sformatf("rst_a_out1_%0d", a), 32'(a_OUT1), 0);
            chk($sformatf("rst_a_v1_%0d", a), 32'(a_V1), 1);
            chk($sformatf("rst_b_out2_%0d", a), 32'(b_OUT2), 0);
            chk($sformatf("rst_b_v2_%0d", a), 32'(b_V2), 1);
        end
        chk("rst_a_coll", 32'(a_COLL), 0);
        chk("rst_b_coll", 32'(b_COLL), 0);

        // dual write, distinct addresses
        tick();
        WRITE1 = 1; INADDRESS1 = 3'd2; IN1 = 8'd95;
        WRITE2 = 1; INADDRESS2 = 3'd5; IN2 = 8'd28;
        tick();
        idle();
        OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd5;
        #1;
        chk("dual_a_r2", 32'(a_OUT1), 95);
        chk("dual_a_r5", 32'(a_OUT2), 28);
        chk("dual_b_r2", 32'(b_OUT1), 95);
        chk("dual_b_r5", 32'(b_OUT2), 28);
        chk("dual_a_coll", 32'(a_COLL), 0);

        // same-address dual write
        WRITE1 = 1; INADDRESS1 = 3'd4; IN1 = 8'd6;
        WRITE2 = 1; INADDRESS2 = 3'd4; IN2 = 8'd15;
        tick();
        idle();
        OUT1ADDRESS = 3'd4;
        #1;
        chk("coll_a_r4", 32'(a_OUT1), 6);
        chk("coll_b_r4", 32'(b_OUT1), 6);
        chk("coll_a_flag", 32'(a_COLL), 1);
        chk("coll_b_flag", 32'(b_COLL), 1);
        tick();
        chk("coll_a_drop", 32'(a_COLL), 0);
        chk("coll_b_drop", 32'(b_COLL), 0);

        // reserve r7, then satisfy it
        RESERVE = 1; RESADDRESS = 3'd7;
        tick();
        idle();
        OUT1ADDRESS = 3'd7;
        #1;
        chk("res_a_v7", 32'(a_V1), 0);
        chk("res_b_v7", 32'(b_V1), 0);
        WRITE1 = 1; INADDRESS1 = 3'd7; IN1 = 8'd15;
        #1;
        chk("res_a_v7_pre", 32'(a_V1), 0);
        chk("res_b_v7_byp", 32'(b_V1), 1);
        chk("res_b_r7_byp", 32'(b_OUT1), 15);
        tick();
        idle();
        #1;
        chk("res_a_v7_done", 32'(a_V1), 1);
        chk("res_a_r7", 32'(a_OUT1), 15);
        chk("res_b_v7_done", 32'(b_V1), 1);

        // reserve and write the same register in one cycle
        RESERVE = 1; RESADDRESS = 3'd3;
        WRITE1 = 1; INADDRESS1 = 3'd3; IN1 = 8'd50;
        OUT1ADDRESS = 3'd3;
        #1;
        chk("rw_a_r3_pre", 32'(a_OUT1), 0);
        chk("rw_b_r3_byp", 32'(b_OUT1), 50);
        chk("rw_b_v3_byp", 32'(b_V1), 0);
        tick();
        idle();
        #1;
        chk("rw_a_r3", 32'(a_OUT1), 50);
        chk("rw_a_v3", 32'(a_V1), 0);
        chk("rw_b_v3", 32'(b_V1), 0);

        // bypass of port 1 onto read port 2
        WRITE1 = 1; INADDRESS1 = 3'd1; IN1 = 8'd28;
        tick();
        WRITE1 = 1; INADDRESS1 = 3'd1; IN1 = 8'd50;
        OUT2ADDRESS = 3'd1;
        #1;
        chk("byp_a_r1_old", 32'(a_OUT2), 28);
        chk("byp_b_r1_new", 32'(b_OUT2), 50);
        tick();
        idle();
        #1;
        chk("byp_a_r1", 32'(a_OUT2), 50);

        // port 1 wins the forward on a shared target
        WRITE1 = 1; INADDRESS1 = 3'd6; IN1 = 8'd11;
        WRITE2 = 1; INADDRESS2 = 3'd6; IN2 = 8'd22;
        OUT2ADDRESS = 3'd6;
        #1;
        chk("byp_b_prio", 32'(b_OUT2), 11);
        tick();
        idle();
        // port 2 forward onto read port 1
        WRITE2 = 1; INADDRESS2 = 3'd5; IN2 = 8'd77;
        OUT1ADDRESS = 3'd5;
        #1;
        chk("byp_a_r5_old", 32'(a_OUT1), 28);
        chk("byp_b_r5_new", 32'(b_OUT1), 77);
        tick();
        idle();
        #1;
        chk("byp_a_r5", 32'(a_OUT1), 77);
        chk("byp_a_r6", 32'(a_OUT2), 11);

        // register 0 hardwired in instance b
        WRITE1 = 1; INADDRESS1 = 3'd0; IN1 = 8'd99;
        OUT1ADDRESS = 3'd0;
        #1;
        chk("z_b_r0_byp", 32'(b_OUT1), 0);
        tick();
        idle();
        RESERVE = 1; RESADDRESS = 3'd0;
        tick();
        idle();
        #1;
        chk("z_a_r0", 32'(a_OUT1), 99);
        chk("z_b_r0", 32'(b_OUT1), 0);
        chk("z_a_v0", 32'(a_V1), 0);
        chk("z_b_v0", 32'(b_V1), 1);

        // reserve r6, then reset mid-run with ignored traffic
        RESERVE = 1; RESADDRESS = 3'd6;
        tick();
        idle();
        OUT2ADDRESS = 3'd6;
        #1;
        chk("mr_a_v6", 32'(a_V2), 0);
        chk("mr_b_v6", 32'(b_V2), 0);
        RESET = 1;
        WRITE1 = 1; INADDRESS1 = 3'd6; IN1 = 8'd44;
        RESERVE = 1; RESADDRESS = 3'd2;
        #1;
        chk("mr_a_r6_hold", 32'(a_OUT2), 11);
        chk("mr_a_v6_hold", 32'(a_V2), 0);
        tick();
        idle();
        OUT1ADDRESS = 3'd2;
        #1;
        chk("mr_a_r6", 32'(a_OUT2), 0);
        chk("mr_a_v6_clr", 32'(a_V2), 1);
        chk("mr_b_v6_clr", 32'(b_V2), 1);
        chk("mr_a_r2", 32'(a_OUT1), 0);
        chk("mr_a_v2", 32'(a_V1), 1);
        OUT1ADDRESS = 3'd0;
        #1;
        chk("mr_a_r0", 32'(a_OUT1), 0);
        chk("mr_a_v0", 32'(a_V1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
